// File: rtl/data_memory_responder.sv
// Data-port memory responder for the multicycle core. It takes one request at a time,
// waits a fixed latency, then performs a byte-enabled write or a full-word read.
module data_memory_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dReq,
  input  logic        dWE,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  input  logic [3:0]  dByteEn,
  output logic [31:0] dReadData,
  output logic        dReady,
  output logic        dErr
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam int          CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              we_reg;
  logic [31:0]       addr_reg;
  logic [31:0]       wdata_reg;
  logic [3:0]        be_reg;
  logic [31:0]       rdata_reg;
  logic              ready_reg;
  logic              err_reg;

  logic [31:0]       offset;
  logic              addr_valid;
  logic [AW-1:0]     word_idx;
  logic              commit;
  logic [31:0]       rd_word;

  // Decode works on the captured address so late input changes cannot leak in.
  assign offset     = addr_reg - BASE_ADDR;
  assign addr_valid = (addr_reg[1:0] == 2'b00) && (offset < SPAN);
  assign word_idx   = offset[AW+1:2];

  // RESP is the last latency cycle; its closing edge is the commit/capture edge.
  assign commit = (state_reg == RESP) && !rst;

  // One byte-wide array per lane keeps byte enables a plain per-lane write enable.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];

      always_ff @(posedge clk) begin
        if (commit && we_reg && addr_valid && be_reg[gi]) begin
          lane_mem[word_idx] <= wdata_reg[8*gi +: 8];
        end
      end

      assign rd_word[8*gi +: 8] = lane_mem[word_idx];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
      rdata_reg <= '0;
      ready_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      ready_reg <= 1'b0;
      err_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (dReq) begin
            we_reg    <= dWE;
            addr_reg  <= dAddress;
            wdata_reg <= dWriteData;
            be_reg    <= dByteEn;
            if (LATENCY == 1) begin
              state_reg <= RESP;
            end else begin
              state_reg <= BUSY;
              cnt_reg   <= CNT_W'(LATENCY > 1 ? LATENCY - 2 : 0);
            end
          end
        end
        BUSY: begin
          if (cnt_reg == '0) begin
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        RESP: begin
          ready_reg <= 1'b1;
          err_reg   <= !addr_valid;
          rdata_reg <= (addr_valid && !we_reg) ? rd_word : 32'h0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign dReadData = rdata_reg;
  assign dReady    = ready_reg;
  assign dErr      = err_reg;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: one instance at LATENCY=2, one at LATENCY=1.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wd0, addr1, wd1;
  logic [3:0]  be0, be1;
  logic [31:0] rd0, rd1;
  logic        rdy0, err0, rdy1, err1;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  data_memory_responder #(.BASE_ADDR(32'h10010000), .DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .dReq(req0), .dWE(we0), .dAddress(addr0),
    .dWriteData(wd0), .dByteEn(be0), .dReadData(rd0), .dReady(rdy0), .dErr(err0)
  );

  data_memory_responder #(.BASE_ADDR(32'h10010000), .DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .dReq(req1), .dWE(we1), .dAddress(addr1),
    .dWriteData(wd1), .dByteEn(be1), .dReadData(rd1), .dReady(rdy1), .dErr(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One full transaction; inputs are scrambled right after acceptance.
  task automatic xact(input bit sel, input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] be,
                      input logic [31:0] exp_rd, input logic exp_err);
    int cyc;
    logic got;
    @(negedge clk);
    if (sel) begin req1 = 1; we1 = we; addr1 = addr; wd1 = data; be1 = be; end
    else     begin req0 = 1; we0 = we; addr0 = addr; wd0 = data; be0 = be; end
    @(posedge clk);
    #1;
    if (sel) begin req1 = 0; we1 = ~we; addr1 = ~addr; wd1 = ~data; be1 = ~be; end
    else     begin req0 = 0; we0 = ~we; addr0 = ~addr; wd0 = ~data; be0 = ~be; end
    cyc = 0;
    got = 0;
    while (!got && cyc < 8) begin
      @(posedge clk);
      #1;
      cyc++;
      got = sel ? rdy1 : rdy0;
    end
    chk({tag, "_latency"}, 32'(cyc), sel ? 32'd1 : 32'd2);
    chk({tag, "_err"}, {31'h0, sel ? err1 : err0}, {31'h0, exp_err});
    chk({tag, "_rdata"}, sel ? rd1 : rd0, exp_rd);
    $display("xact %s we=%0b addr=%h wd=%h be=%b -> rd=%h err=%0b cyc=%0d", tag, we, addr, data,
             be, sel ? rd1 : rd0, sel ? err1 : err0, cyc);
  endtask

  initial begin
    logic [11:0] pat;
    int seen;
    rst = 1;
    req0 = 0; we0 = 0; addr0 = 0; wd0 = 0; be0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wd1 = 0; be1 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {31'h0, rdy0}, 32'h0);
    chk("reset_err", {31'h0, err0}, 32'h0);
    chk("reset_rdata", rd0, 32'h0);
    rst = 0;

    // Basic write/read
    xact(0, "wr_beef", 1, 32'h10010010, 32'hDEADBEEF, 4'hF, 32'h0, 0);
    xact(0, "rd_beef", 0, 32'h10010010, 32'h0, 4'h0, 32'hDEADBEEF, 0);

    // Byte enables
    xact(0, "wr_w0", 1, 32'h10010000, 32'h11223344, 4'hF, 32'h0, 0);
    xact(0, "wr_be", 1, 32'h10010000, 32'hAABBCCDD, 4'b0101, 32'h0, 0);
    xact(0, "rd_be", 0, 32'h10010000, 32'h0, 4'h3, 32'h11BB33DD, 0);
    xact(0, "wr_be0", 1, 32'h10010010, 32'h00000000, 4'h0, 32'h0, 0);
    xact(0, "rd_be0", 0, 32'h10010010, 32'h0, 4'h0, 32'hDEADBEEF, 0);

    // Bounds
    xact(0, "wr_top", 1, 32'h100103FC, 32'hCAFEF00D, 4'hF, 32'h0, 0);
    xact(0, "rd_top", 0, 32'h100103FC, 32'h0, 4'h0, 32'hCAFEF00D, 0);
    xact(0, "rd_over", 0, 32'h10010400, 32'h0, 4'h0, 32'h0, 1);
    xact(0, "rd_under", 0, 32'h1000FFFC, 32'h0, 4'h0, 32'h0, 1);
    xact(0, "wr_over", 1, 32'h10010400, 32'h55555555, 4'hF, 32'h0, 1);
    xact(0, "rd_w0_a", 0, 32'h10010000, 32'h0, 4'h0, 32'h11BB33DD, 0);
    xact(0, "rd_top_a", 0, 32'h100103FC, 32'h0, 4'h0, 32'hCAFEF00D, 0);

    // Misaligned
    xact(0, "wr_mis", 1, 32'h10010002, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
    xact(0, "rd_w0_b", 0, 32'h10010000, 32'h0, 4'h0, 32'h11BB33DD, 0);

    // Continuous dReq, LATENCY=2: pulses at post-edge samples 2,5,8,11
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 32'h10010010; be0 = 4'h0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      pat[i] = rdy0;
    end
    req0 = 0;
    chk("hold_req_l2", {20'h0, pat}, 32'h924);
    repeat (3) @(posedge clk);

    // LATENCY=1 instance
    xact(1, "l1_wr", 1, 32'h10010008, 32'h0BADF00D, 4'hF, 32'h0, 0);
    xact(1, "l1_rd", 0, 32'h10010008, 32'h0, 4'h0, 32'h0BADF00D, 0);
    @(negedge clk);
    req1 = 1; we1 = 0; addr1 = 32'h10010008; be1 = 4'h0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      pat[i] = rdy1;
    end
    req1 = 0;
    chk("hold_req_l1", {20'h0, pat}, 32'hAAA);
    repeat (3) @(posedge clk);

    // Reset during BUSY of a write
    xact(0, "wr_zero", 1, 32'h10010020, 32'h00000000, 4'hF, 32'h0, 0);
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 32'h10010020; wd0 = 32'h12345678; be0 = 4'hF;
    @(posedge clk);
    #1;
    req0 = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (rdy0) seen++;
    end
    chk("rst_no_ready", 32'(seen), 32'h0);
    chk("rst_rdata", rd0, 32'h0);
    $display("xact rst_mid_write dReady_pulses=%0d", seen);
    xact(0, "rd_after_rst", 0, 32'h10010020, 32'h0, 4'h0, 32'h0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
